keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per scan tick, >= 2.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4: consecutive matching tick samples needed to accept a press or a release, >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ROWS  input  4  keypad row lines, active-low; ROWS[0] is row 0; externally synchronized.
REQ-006 SHALL have port COLSEL  output  4  column drive, active-low, one-cold; bit i low drives column i.
REQ-007 SHALL have port KEYCODE  output  4  last accepted key, {row[1:0], col[1:0]}.
REQ-008 SHALL have port KEY_VALID  output  1  one-cycle pulse when KEYCODE is updated.
REQ-009 SHALL have port KEY_DOWN  output  1  high from accepted press until accepted release.

Function
REQ-010 SHALL run a prescaler that counts 0..SCAN_DIV-1, wraps to 0, and asserts an internal tick in the cycle its value equals SCAN_DIV-1.
REQ-011 SHALL sample ROWS only in tick cycles; all state changes below happen on the clock edge that ends the tick cycle.
REQ-012 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 In SCAN, with ROWS == 4'b1111 or more than one bit low, SHALL advance the column index by 1, wrapping 3 to 0, and drive COLSEL = ~(4'b0001 << index).
REQ-014 In SCAN, with exactly one ROWS bit low, SHALL capture row and column, set debounce count to 1, hold the column, and go to DEBOUNCE.
REQ-015 In DEBOUNCE, a sample equal to the captured ROWS pattern SHALL increment the count.
REQ-016 In DEBOUNCE, when the count reaches DEBOUNCE_TICKS, SHALL load KEYCODE, pulse KEY_VALID in the next cycle only, set KEY_DOWN, and go to HELD.
REQ-017 In DEBOUNCE, any sample differing from the captured pattern SHALL clear the count, advance the column and return to SCAN, with no KEY_VALID and KEYCODE unchanged.
REQ-018 In HELD, SHALL keep COLSEL on the captured column; a sample of 4'b1111 SHALL set release count to 1 and go to RELEASE; any other sample keeps HELD.
REQ-019 In RELEASE, a 4'b1111 sample SHALL increment the release count; any other sample SHALL return to HELD with count cleared.
REQ-020 When the release count reaches DEBOUNCE_TICKS, SHALL clear KEY_DOWN, advance the column and go to SCAN; KEYCODE holds its value.
REQ-021 A held key SHALL never produce a second KEY_VALID (no auto-repeat); a new pulse requires a full release first.
REQ-022 A second key pressed while in HELD or RELEASE SHALL be ignored until release is accepted.
REQ-023 KEY_VALID and KEY_DOWN SHALL be registered outputs; COLSEL SHALL change only on clock edges.
REQ-024 Counters SHALL be sized for the parameters with no overflow; count saturates by state exit.

Reset
REQ-025 rst high at a rising edge SHALL force: state SCAN, column index 0, COLSEL = 4'b1110, KEYCODE = 4'h0, KEY_VALID = 0, KEY_DOWN = 0, prescaler and debounce counts 0.
REQ-026 Reset asserted mid-debounce or while a key is held SHALL abort with no KEY_VALID; scanning restarts at column 0 on the first edge after rst deasserts.

Verification (bench parameters SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-027 Idle: rst then ROWS=4'b1111 for 32 cycles -> COLSEL steps 1110,1101,1011,0111,1110 every 4 cycles; KEY_VALID never high.
REQ-028 Clean press: ROWS=4'b1011 whenever COLSEL=4'b1101, held -> single KEY_VALID pulse, KEYCODE=4'h9, KEY_DOWN=1, COLSEL frozen at 1101.
REQ-029 Bounce: ROWS low for 2 samples, then high -> no KEY_VALID, KEYCODE unchanged, scanning resumes with next column.
REQ-030 Release: after REQ-028, ROWS=4'b1111 for 2 samples, then 4'b1011, then 4'b1111 for 3 samples -> KEY_DOWN falls only after the final 3 samples, no second pulse.
REQ-031 Multi-key: ROWS=4'b0011 in SCAN -> ignored, column advances, no KEY_VALID.
REQ-032 Reset mid-operation: rst pulsed during DEBOUNCE, then in HELD -> outputs match REQ-025 the next cycle; no KEY_VALID emitted.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner. It drives the columns one at a time (active-low), debounces a single-key
// press and the later release on a prescaled scan tick, and reports each accepted key exactly once.
module keypad_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ROWS,
  output logic [3:0] COLSEL,
  output logic [3:0] KEYCODE,
  output logic       KEY_VALID,
  output logic       KEY_DOWN,
  output logic [1:0] state_o
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    S_SCAN    = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [1:0]       col_q, col_inc, cap_row_q;
  logic [3:0]       colsel_q, cap_rows_q, keycode_q;
  logic             key_valid_q, key_down_q;
  logic             tick, single_low, cnt_done;
  logic [1:0]       row_idx;
  logic [3:0]       rows_low;

  // The tick is high in the last cycle of each SCAN_DIV-cycle period.
  assign tick = (div_q == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (tick) div_d = '0;
  end

  always_comb begin
    rows_low   = ~ROWS;
    single_low = (rows_low != 4'h0) && ((rows_low & (rows_low - 4'h1)) == 4'h0);
    row_idx    = 2'd0;
    case (rows_low)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cnt_done = (cnt_inc == CNT_W'(DEBOUNCE_TICKS));
  assign col_inc  = col_q + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  // KEY_VALID is a one-cycle strobe with no back-pressure: it is high for exactly the cycle after a
  // press is accepted, and KEYCODE holds that key until the next accepted press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SCAN;
      col_q       <= 2'd0;
      colsel_q    <= 4'b1110;
      cnt_q       <= '0;
      cap_rows_q  <= 4'hF;
      cap_row_q   <= 2'd0;
      keycode_q   <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_SCAN: begin
            if (single_low) begin
              cap_rows_q <= ROWS;
              cap_row_q  <= row_idx;
              cnt_q      <= CNT_W'(1);
              state_q    <= S_DEBOUNCE;
            end else begin
              col_q    <= col_inc;
              colsel_q <= ~(4'b0001 << col_inc);
            end
          end
          S_DEBOUNCE: begin
            if (ROWS == cap_rows_q) begin
              if (cnt_done) begin
                keycode_q   <= {cap_row_q, col_q};
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
                cnt_q       <= '0;
                state_q     <= S_HELD;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q    <= '0;
              col_q    <= col_inc;
              colsel_q <= ~(4'b0001 << col_inc);
              state_q  <= S_SCAN;
            end
          end
          S_HELD: begin
            // Any pattern other than all-high, including a second key, keeps the key held.
            if (ROWS == 4'hF) begin
              cnt_q   <= CNT_W'(1);
              state_q <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (ROWS == 4'hF) begin
              if (cnt_done) begin
                key_down_q <= 1'b0;
                cnt_q      <= '0;
                col_q      <= col_inc;
                colsel_q   <= ~(4'b0001 << col_inc);
                state_q    <= S_SCAN;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= S_HELD;
            end
          end
          default: state_q <= S_SCAN;
        endcase
      end
    end
  end

  assign COLSEL    = colsel_q;
  assign KEYCODE   = keycode_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_DOWN  = key_down_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_TICKS=3: idle scan, press, release,
// bounce, multi-key and reset aborts, every step checked against hand-computed values.
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DT = 3;
  localparam logic [1:0] ST_SCAN = 2'd0, ST_DEB = 2'd1, ST_HELD = 2'd2, ST_REL = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rows = 4'hF;
  logic [3:0] colsel, keycode;
  logic       key_valid, key_down;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int kv_count = 0;

  logic [3:0] col_tab [4];
  logic [1:0] exp_col;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .ROWS(rows), .COLSEL(colsel), .KEYCODE(keycode),
    .KEY_VALID(key_valid), .KEY_DOWN(key_down), .state_o(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (key_valid === 1'b1) kv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds rows for one full scan period; returns 1 time unit after the edge that ends the tick.
  task automatic tick_step(input logic [3:0] r);
    rows = r;
    repeat (SD) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst  = 1'b1;
    rows = 4'hF;
    @(posedge clk);
    #1;
    check("rst_state", state, ST_SCAN);
    check("rst_colsel", colsel, 4'b1110);
    check("rst_keycode", keycode, 4'h0);
    check("rst_kv", key_valid, 1'b0);
    check("rst_kd", key_down, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    col_tab[0] = 4'b1110;
    col_tab[1] = 4'b1101;
    col_tab[2] = 4'b1011;
    col_tab[3] = 4'b0111;

    repeat (3) @(posedge clk);
    #1;
    check("init_state", state, ST_SCAN);
    check("init_colsel", colsel, 4'b1110);
    check("init_keycode", keycode, 4'h0);
    check("init_kv", key_valid, 1'b0);
    check("init_kd", key_down, 1'b0);
    rst = 1'b0;

    // Idle: the first period is split to pin down the tick phase.
    repeat (SD - 1) @(posedge clk);
    #1;
    check("idle_pre_tick", colsel, 4'b1110);
    @(posedge clk);
    #1;
    check("idle_tick1", colsel, 4'b1101);
    exp_col = 2'd1;
    for (int i = 0; i < 7; i++) begin
      tick_step(4'hF);
      exp_col = exp_col + 2'd1;
      check("idle_colsel", colsel, col_tab[exp_col]);
    end
    check("idle_no_kv", kv_count, 0);

    // Clean press on row 2, column 1.
    tick_step(4'hF);
    check("pre_press_col", colsel, 4'b1101);
    tick_step(4'b1011);
    check("press1_state", state, ST_DEB);
    check("press1_colsel", colsel, 4'b1101);
    tick_step(4'b1011);
    check("press2_state", state, ST_DEB);
    check("press2_no_kv", kv_count, 0);
    tick_step(4'b1011);
    check("press_kv", key_valid, 1'b1);
    check("press_keycode", keycode, 4'h9);
    check("press_kd", key_down, 1'b1);
    check("press_state", state, ST_HELD);
    for (int i = 0; i < 2; i++) begin
      tick_step(4'b1011);
      check("held_colsel", colsel, 4'b1101);
      check("held_kd", key_down, 1'b1);
    end
    check("held_single_kv", kv_count, 1);

    // Release with a relapse after two high samples.
    tick_step(4'hF);
    check("rel1_state", state, ST_REL);
    tick_step(4'hF);
    check("rel2_state", state, ST_REL);
    check("rel2_kd", key_down, 1'b1);
    tick_step(4'b1011);
    check("relapse_state", state, ST_HELD);
    tick_step(4'hF);
    tick_step(4'hF);
    check("rel_b2_kd", key_down, 1'b1);
    check("rel_b2_colsel", colsel, 4'b1101);
    tick_step(4'hF);
    check("rel_done_kd", key_down, 1'b0);
    check("rel_done_state", state, ST_SCAN);
    check("rel_done_colsel", colsel, 4'b1011);
    check("rel_done_keycode", keycode, 4'h9);
    check("rel_no_kv", kv_count, 1);

    // Bounce on column 2: two low samples then high.
    tick_step(4'b1110);
    check("bounce1_state", state, ST_DEB);
    tick_step(4'b1110);
    check("bounce2_state", state, ST_DEB);
    tick_step(4'hF);
    check("bounce_state", state, ST_SCAN);
    check("bounce_colsel", colsel, 4'b0111);
    check("bounce_keycode", keycode, 4'h9);
    check("bounce_no_kv", kv_count, 1);

    // Two rows low together are ignored.
    tick_step(4'b0011);
    check("multi1_state", state, ST_SCAN);
    check("multi1_colsel", colsel, 4'b1110);
    tick_step(4'b0011);
    check("multi2_colsel", colsel, 4'b1101);
    check("multi_no_kv", kv_count, 1);

    // Reset during debounce on column 1.
    tick_step(4'b0111);
    check("deb_before_rst", state, ST_DEB);
    reset_pulse();
    check("rst_deb_no_kv", kv_count, 1);

    // Press row 1, column 0, then reset while held.
    for (int i = 0; i < DT; i++) tick_step(4'b1101);
    check("press2_kv", key_valid, 1'b1);
    check("press2_keycode", keycode, 4'h4);
    check("press2_kd", key_down, 1'b1);
    tick_step(4'b1101);
    check("press2_held", state, ST_HELD);
    check("press2_kv_count", kv_count, 2);
    reset_pulse();
    tick_step(4'hF);
    check("post_rst_colsel", colsel, 4'b1101);
    check("post_rst_kd", key_down, 1'b0);
    check("post_rst_kv_count", kv_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
